// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: start/done handshake between the core and the multiply/divide unit.
//   start  : request strobe (core -> unit)
//   op     : operation select, ALUSel[4:2] (core -> unit)
//   a, b   : rs1 / rs2 operands (core -> unit)
//   busy   : operation in progress (unit -> core)
//   done   : one-cycle completion pulse (unit -> core)
//   result : 32-bit result, held until the next accepted start (unit -> core)
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, input  busy, done, result);
    modport slave  (input  start, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide.
//   Multiply: radix-2 shift-add on magnitudes, 32 iterations.
//   Divide  : restoring shift-subtract on magnitudes, 32 iterations.
//   A final FIX cycle applies sign correction and registers the result.
//   Divide-by-zero and signed overflow skip the iterations (1-cycle latency).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : muldiv_unit_if slave (start/op/a/b in, busy/done/result out)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [5:0]        r_cnt;
    logic [2:0]        r_op;
    logic              r_sa, r_sb, r_spec;
    logic [XLEN-1:0]   r_b;        // |b|: multiplicand or divisor
    logic [2*XLEN-1:0] r_acc;      // multiply: {partial sum, remaining multiplier}
    logic [XLEN-1:0]   r_rem;      // divide: partial remainder (always < |b|)
    logic [XLEN-1:0]   r_q;        // divide: dividend bits out at MSB, quotient bits in at LSB
    logic              r_busy, r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic              w_div0, w_ovf, w_ge;
    logic [XLEN-1:0]   w_amag, w_bmag, w_quo, w_remf, w_fix_res;
    logic [XLEN:0]     w_sum, w_rem_sh;
    logic [2*XLEN-1:0] w_prod;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    assign w_accept   = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div   = bus.op[2];
    // a signed for MUL, MULH, MULHSU, DIV, REM; b signed for MUL, MULH, DIV, REM
    assign w_a_signed = (bus.op != 3'd3) && (bus.op != 3'd5) && (bus.op != 3'd7);
    assign w_b_signed = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    assign w_sa       = w_a_signed && bus.a[XLEN-1];
    assign w_sb       = w_b_signed && bus.b[XLEN-1];
    // |MIN_NEG| wraps to MIN_NEG, which is the correct unsigned magnitude
    assign w_amag     = w_sa ? -bus.a : bus.a;
    assign w_bmag     = w_sb ? -bus.b : bus.b;
    assign w_div0     = w_is_div && (bus.b == '0);
    assign w_ovf      = w_is_div && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1);

    // multiply step: 33-bit sum so the carry lands in bit 63 after the shift
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // divide step
    assign w_rem_sh   = {r_rem, r_q[XLEN-1]};
    assign w_ge       = w_rem_sh >= {1'b0, r_b};

    // sign correction; special-case values are already final
    assign w_prod     = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo      = (!r_spec && (r_sa ^ r_sb)) ? -r_q : r_q;
    assign w_remf     = (!r_spec && r_sa) ? -r_rem : r_rem;

    always_comb begin
        w_fix_res = '0;
        if (r_op[2])
            w_fix_res = r_op[1] ? w_remf : w_quo;
        else
            w_fix_res = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_spec   <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_b    <= w_bmag;
            r_cnt  <= '0;
            r_acc  <= {{XLEN{1'b0}}, w_amag};
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_spec <= w_div0 || w_ovf;
            if (w_div0) begin
                r_q   <= '1;
                r_rem <= bus.a;
            end else if (w_ovf) begin
                r_q   <= MIN_NEG;
                r_rem <= '0;
            end else begin
                r_q   <= w_amag;
                r_rem <= '0;
            end
            r_state <= (w_div0 || w_ovf) ? S_FIX : S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_op[2]) begin
                        r_rem <= w_ge ? XLEN'(w_rem_sh - {1'b0, r_b}) : XLEN'(w_rem_sh);
                        r_q   <= {r_q[XLEN-2:0], w_ge};
                    end else begin
                        r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule
